// File: rtl/lock_in_demod_core_if.sv
// Sample/reference/control inputs and demodulated result outputs of the lock-in core.
// The master side drives samples and configuration; the slave side is the demodulator.
interface lock_in_demod_core_if #(
  parameter int ADC_W = 14,
  parameter int REF_W = 14,
  parameter int OUT_W = 14,
  parameter int CNT_W = 20
);
  logic signed [ADC_W-1:0] adc_i;
  logic signed [REF_W-1:0] ref_i_i;
  logic signed [REF_W-1:0] ref_q_i;
  logic                    enable_i;
  logic                    ext_mode_i;
  logic                    sync_i;
  logic        [CNT_W-1:0] period_i;
  logic              [5:0] shift_i;
  logic signed [OUT_W-1:0] i_o;
  logic signed [OUT_W-1:0] q_o;
  logic                    valid_o;
  logic                    sat_o;
  logic signed [OUT_W-1:0] mux_o;
  logic                    mux_sel_o;

  modport master (
    output adc_i, ref_i_i, ref_q_i, enable_i, ext_mode_i, sync_i, period_i, shift_i,
    input  i_o, q_o, valid_o, sat_o, mux_o, mux_sel_o
  );

  modport slave (
    input  adc_i, ref_i_i, ref_q_i, enable_i, ext_mode_i, sync_i, period_i, shift_i,
    output i_o, q_o, valid_o, sat_o, mux_o, mux_sel_o
  );
endinterface

// File: rtl/lock_in_demod_core.sv
// Dual-phase lock-in demodulator: sample x reference products integrated over a window,
// then shifted and saturated into I/Q results plus an I-then-Q multiplexed stream.
module lock_in_demod_core #(
  parameter int ADC_W = 14,
  parameter int REF_W = 14,
  parameter int OUT_W = 14,
  parameter int ACC_W = 48,
  parameter int CNT_W = 20
) (
  input logic                  dac_clk_i,
  input logic                  dac_rstn_i,
  lock_in_demod_core_if.slave  bus
);
  localparam int PRD_W = ADC_W + REF_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  logic signed [ADC_W-1:0] adc_s1;
  logic signed [REF_W-1:0] ri_s1, rq_s1;
  logic                    en_s1, sync_s1;
  logic signed [PRD_W-1:0] pi_s2, pq_s2;
  logic                    en_s2, sync_s2;
  state_t                  state;
  logic signed [ACC_W-1:0] acc_i, acc_q, res_i, res_q, shr_i, shr_q;
  logic        [CNT_W-1:0] cnt, per_l, next_per;
  logic                    ext_l, dump_s3, dv4;
  logic              [5:0] shift_s3;
  logic signed [ACC_W-1:0] p_i, p_q, sum_i, sum_q;
  logic signed [OUT_W-1:0] cl_i, cl_q;
  logic                    ov_i, ov_q, tc, dump;

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      adc_s1 <= '0; ri_s1 <= '0; rq_s1 <= '0; en_s1 <= 1'b0; sync_s1 <= 1'b0;
      pi_s2 <= '0; pq_s2 <= '0; en_s2 <= 1'b0; sync_s2 <= 1'b0;
    end else begin
      adc_s1  <= bus.adc_i;
      ri_s1   <= bus.ref_i_i;
      rq_s1   <= bus.ref_q_i;
      en_s1   <= bus.enable_i;
      sync_s1 <= bus.sync_i;
      pi_s2   <= PRD_W'(adc_s1) * PRD_W'(ri_s1);
      pq_s2   <= PRD_W'(adc_s1) * PRD_W'(rq_s1);
      en_s2   <= en_s1;
      sync_s2 <= sync_s1;
    end
  end

  always_comb begin
    p_i      = en_s2 ? ACC_W'(pi_s2) : '0;
    p_q      = en_s2 ? ACC_W'(pq_s2) : '0;
    sum_i    = sat_add(acc_i, p_i);
    sum_q    = sat_add(acc_q, p_q);
    tc       = !ext_l && en_s2 && (cnt == per_l - CNT_W'(1));
    dump     = sync_s2 || tc;
    next_per = (bus.period_i < CNT_W'(2)) ? CNT_W'(2) : bus.period_i;
  end

  // Window control: a dump closes the current window including the product in flight;
  // window length and mode are picked up only when a new window opens.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state <= IDLE;
      acc_i <= '0; acc_q <= '0; res_i <= '0; res_q <= '0;
      cnt <= '0; per_l <= CNT_W'(2); ext_l <= 1'b0;
      dump_s3 <= 1'b0; shift_s3 <= '0;
    end else begin
      dump_s3 <= dump;
      if (dump) begin
        res_i    <= sum_i;
        res_q    <= sum_q;
        shift_s3 <= bus.shift_i;
        acc_i    <= '0;
        acc_q    <= '0;
        cnt      <= '0;
        per_l    <= next_per;
        ext_l    <= bus.ext_mode_i;
      end else begin
        if (state == IDLE) begin
          per_l <= next_per;
          ext_l <= bus.ext_mode_i;
        end
        if (en_s2) begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          if (!ext_l) cnt <= cnt + CNT_W'(1);
        end
      end
      if (state == IDLE && en_s2) state <= RUN;
    end
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      shr_i <= '0; shr_q <= '0; dv4 <= 1'b0;
    end else begin
      shr_i <= res_i >>> shift_s3;
      shr_q <= res_q >>> shift_s3;
      dv4   <= dump_s3;
    end
  end

  always_comb begin
    ov_i = (shr_i > OUT_MAX) || (shr_i < OUT_MIN);
    ov_q = (shr_q > OUT_MAX) || (shr_q < OUT_MIN);
    cl_i = (shr_i > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : (shr_i < OUT_MIN) ? OUT_MIN[OUT_W-1:0] : shr_i[OUT_W-1:0];
    cl_q = (shr_q > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : (shr_q < OUT_MIN) ? OUT_MIN[OUT_W-1:0] : shr_q[OUT_W-1:0];
  end

  // A fresh result always claims the mux, even on the cycle reserved for the previous Q.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      bus.i_o <= '0; bus.q_o <= '0; bus.valid_o <= 1'b0; bus.sat_o <= 1'b0;
      bus.mux_o <= '0; bus.mux_sel_o <= 1'b0;
    end else begin
      bus.valid_o <= dv4;
      if (dv4) begin
        bus.i_o       <= cl_i;
        bus.q_o       <= cl_q;
        bus.sat_o     <= ov_i || ov_q;
        bus.mux_o     <= cl_i;
        bus.mux_sel_o <= 1'b0;
      end else if (bus.valid_o) begin
        bus.mux_o     <= bus.q_o;
        bus.mux_sel_o <= 1'b1;
      end else begin
        bus.mux_o     <= '0;
        bus.mux_sel_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lock_in_demod_core.sv
// Randomised scoreboard bench for lock_in_demod_core: a window-sum model predicts each
// result when its closing sample is issued; a monitor compares on every valid_o.
module tb_lock_in_demod_core;
  localparam int ADC_W = 14, REF_W = 14, OUT_W = 14, ACC_W = 48, CNT_W = 20;

  typedef struct { int i; int q; bit s; } exp_t;

  logic dac_clk_i = 1'b0;
  logic dac_rstn_i = 1'b0;
  lock_in_demod_core_if #(.ADC_W(ADC_W), .REF_W(REF_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus();
  lock_in_demod_core #(.ADC_W(ADC_W), .REF_W(REF_W), .OUT_W(OUT_W), .ACC_W(ACC_W), .CNT_W(CNT_W))
    dut (.dac_clk_i(dac_clk_i), .dac_rstn_i(dac_rstn_i), .bus(bus));

  always #4 dac_clk_i = ~dac_clk_i;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  int     cfg_period, cfg_shift;
  bit     cfg_ext;
  longint win_i, win_q;
  int     win_n, win_len;
  bit     win_ext, started;

  function automatic longint clamp_acc(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (ACC_W-1)) - 1;
    lo = -(longint'(1) <<< (ACC_W-1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic void scale(input longint s, input int sh, output int r, output bit c);
    longint t;
    t = s >>> sh;
    c = 1'b0;
    if (t > 8191) begin t = 8191; c = 1'b1; end
    if (t < -8192) begin t = -8192; c = 1'b1; end
    r = int'(t);
  endfunction

  function automatic void open_window();
    win_i = 0; win_q = 0; win_n = 0;
    win_len = (cfg_period < 2) ? 2 : cfg_period;
    win_ext = cfg_ext;
  endfunction

  task automatic check_output(input string name, input int ai, input int aq, input bit as_,
                              input int ei, input int eq, input bit es);
    checks++;
    if (ai != ei || aq != eq || as_ != es) begin
      errors++;
      $display("[TB] FAIL %s: got i=%0d q=%0d sat=%0d, expected i=%0d q=%0d sat=%0d",
               name, ai, aq, as_, ei, eq, es);
    end
  endtask

  task automatic apply_stimulus(input int a, input int ri, input int rq, input bit en, input bit sy);
    exp_t e;
    longint pi, pq;
    bit closes;
    @(posedge dac_clk_i);
    #1;
    bus.adc_i = 14'(a); bus.ref_i_i = 14'(ri); bus.ref_q_i = 14'(rq);
    bus.enable_i = en; bus.sync_i = sy;
    if (!started) open_window();
    pi = en ? longint'(a) * longint'(ri) : 0;
    pq = en ? longint'(a) * longint'(rq) : 0;
    closes = sy || (!win_ext && en && (win_n + 1 == win_len));
    win_i = clamp_acc(win_i + pi);
    win_q = clamp_acc(win_q + pq);
    if (en) win_n++;
    if (closes) begin
      bit si, sq;
      scale(win_i, cfg_shift, e.i, si);
      scale(win_q, cfg_shift, e.q, sq);
      e.s = si | sq;
      exp_q.push_back(e);
      open_window();
    end
    if (en) started = 1'b1;
  endtask

  task automatic set_config(input int period, input int shift, input bit ext);
    cfg_period = period; cfg_shift = shift; cfg_ext = ext;
    bus.period_i = CNT_W'(period); bus.shift_i = 6'(shift); bus.ext_mode_i = ext;
  endtask

  task automatic do_reset();
    @(posedge dac_clk_i);
    #3;
    dac_rstn_i = 1'b0;
    #1;
    checks++;
    if (bus.i_o != 0 || bus.q_o != 0 || bus.valid_o || bus.sat_o || bus.mux_o != 0 || bus.mux_sel_o) begin
      errors++;
      $display("[TB] FAIL async_reset: got i=%0d q=%0d valid=%0d sat=%0d mux=%0d sel=%0d, expected all 0",
               bus.i_o, bus.q_o, bus.valid_o, bus.sat_o, bus.mux_o, bus.mux_sel_o);
    end
    exp_q.delete();
    started = 1'b0;
    open_window();
    bus.enable_i = 1'b0; bus.sync_i = 1'b0;
    repeat (2) @(posedge dac_clk_i);
    #3;
    dac_rstn_i = 1'b1;
  endtask

  task automatic drain();
    repeat (10) apply_stimulus(0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  bit prev_valid = 1'b0;
  int prev_q = 0;
  always @(negedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      prev_valid = 1'b0;
    end else begin
      int em, es;
      exp_t e;
      if (bus.valid_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_valid: got valid=1 i=%0d q=%0d, expected no result", bus.i_o, bus.q_o);
          em = int'(bus.i_o);
        end else begin
          e = exp_q.pop_front();
          check_output("result", int'(bus.i_o), int'(bus.q_o), bus.sat_o, e.i, e.q, e.s);
          em = e.i;
          prev_q = e.q;
        end
        es = 0;
      end else if (prev_valid) begin
        em = prev_q; es = 1;
      end else begin
        em = 0; es = 0;
      end
      checks++;
      if (int'(bus.mux_o) != em || int'(bus.mux_sel_o) != es) begin
        errors++;
        $display("[TB] FAIL mux: got mux=%0d sel=%0d, expected mux=%0d sel=%0d", bus.mux_o, bus.mux_sel_o, em, es);
      end
      prev_valid = bus.valid_o && (exp_q.size() >= 0);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.adc_i = '0; bus.ref_i_i = '0; bus.ref_q_i = '0; bus.enable_i = 1'b0; bus.sync_i = 1'b0;
    set_config(125, 17, 1'b0);
    do_reset();

    repeat (250) apply_stimulus(1000, 8191, 0, 1'b1, 1'b0);
    drain();
    set_config(125, 17, 1'b0);
    do_reset();
    repeat (250) apply_stimulus(-1000, 8191, 0, 1'b1, 1'b0);
    drain();
    set_config(125, 0, 1'b0);
    do_reset();
    repeat (250) apply_stimulus(((($urandom & 1) != 0) ? 1000 : -1000), 8191, 0, 1'b1, 1'b0);
    drain();

    set_config(7, 0, 1'b1);
    do_reset();
    for (int k = 0; k < 100; k++) apply_stimulus(100, 0, -100, 1'b1, (k % 50) == 49);
    drain();
    set_config(7, 7, 1'b1);
    do_reset();
    for (int k = 0; k < 100; k++) apply_stimulus(100, 0, -100, 1'b1, (k % 50) == 49);
    drain();

    set_config(10, 4, 1'b0);
    do_reset();
    for (int k = 0; k < 80; k++)
      apply_stimulus($urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192,
                     $urandom_range(0, 16383) - 8192, (k % 2) == 0, 1'b0);
    drain();

    set_config(10, 2, 1'b0);
    do_reset();
    for (int k = 0; k < 14; k++) apply_stimulus(300 + k, 200, -50, 1'b1, k == 9 || k == 10 || k == 11);
    apply_stimulus(5, 5, 5, 1'b0, 1'b1);
    apply_stimulus(5, 5, 5, 1'b0, 1'b1);
    drain();

    set_config(20, 3, 1'b0);
    do_reset();
    repeat (30) apply_stimulus(777, 4000, -3000, 1'b1, 1'b0);
    do_reset();
    repeat (20) apply_stimulus(777, 4000, -3000, 1'b1, 1'b0);
    drain();

    for (int c = 0; c < 8; c++) begin
      set_config($urandom_range(0, 25), $urandom_range(0, 30), $urandom_range(0, 3) == 0);
      do_reset();
      for (int k = 0; k < 150; k++)
        apply_stimulus($urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192,
                       $urandom_range(0, 16383) - 8192, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 30) == 0);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
